chs_conf_deserializer: RTL and testbench

- Upstream stage of the cool/heat system configuration path.
- Receives the 8-bit chs_conf word serially with a trailing even-parity bit and assembles it.
- Hands the word to the ones-count/parity stage over a valid/ready handshake.
- Also produces a running ones count and is_even flag so the consumer can cross-check its own result.

---
 rtl/chs_conf_deserializer_pkg.sv | 14 +
 rtl/chs_conf_deserializer_if.sv | 30 +++
 rtl/chs_conf_deserializer_sipo_reg.sv | 36 +++
 rtl/chs_conf_deserializer.sv | 119 +++++++++++
 tb/tb_chs_conf_deserializer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/chs_conf_deserializer_pkg.sv
// Shared definitions for the chs_conf deserializer: default widths and FSM state encodings.
package chs_conf_deserializer_pkg;

  localparam int CHS_DATA_W = 8;
  localparam int CHS_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } chs_state_e;

endpackage

// File: rtl/chs_conf_deserializer_if.sv
// Serial input / parallel handshake bundle between the bit source, the deserializer and its consumer.
interface chs_conf_deserializer_if
  import chs_conf_deserializer_pkg::*;
#(
  parameter int DATA_W = CHS_DATA_W,
  parameter int CNT_W  = CHS_CNT_W
);

  logic              start;
  logic              serial_in;
  logic              bit_valid;
  logic              conf_ready;
  logic [DATA_W-1:0] chs_conf;
  logic [CNT_W-1:0]  ones_count;
  logic              is_even;
  logic              parity_err;
  logic              conf_valid;
  logic              busy;

  modport master (
    output start, serial_in, bit_valid, conf_ready,
    input  chs_conf, ones_count, is_even, parity_err, conf_valid, busy
  );

  modport slave (
    input  start, serial_in, bit_valid, conf_ready,
    output chs_conf, ones_count, is_even, parity_err, conf_valid, busy
  );

endinterface

// File: rtl/chs_conf_deserializer_sipo_reg.sv
// Serial-in parallel-out register; each accepted bit lands at the position named by idx (LSB first).
module chs_sipo_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              din,
  input  logic [CNT_W-1:0]  idx,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (shift_en) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (idx == CNT_W'(i)) q_d[i] = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/chs_conf_deserializer.sv
// Assembles an LSB-first serial chs_conf word plus trailing even-parity bit and offers it on valid/ready.
//   IDLE   | waiting for start
//   SHIFT  | accepting data bits
//   PARITY | waiting for the parity bit
//   DONE   | word presented, waiting for conf_ready
module chs_conf_deserializer
  import chs_conf_deserializer_pkg::*;
#(
  parameter int DATA_W = CHS_DATA_W,
  parameter int CNT_W  = CHS_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  chs_conf_deserializer_if.slave  bus
);

  chs_state_e        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] conf_q, conf_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic              perr_q, perr_d;

  logic              start_frame;
  logic              sipo_clr;
  logic              sipo_en;
  logic [DATA_W-1:0] sipo_q;

  // In DONE a start only counts when it coincides with the handshake.
  assign start_frame = (state_q == DONE) ? (bus.start && bus.conf_ready) : bus.start;

  chs_sipo_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sipo_clr),
    .shift_en (sipo_en),
    .din      (bus.serial_in),
    .idx      (idx_q),
    .q        (sipo_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_frame) state_d = SHIFT;
      end
      SHIFT: begin
        if (start_frame) state_d = SHIFT;
        else if (bus.bit_valid && (idx_q == CNT_W'(DATA_W - 1))) state_d = PARITY;
      end
      PARITY: begin
        if (start_frame)        state_d = SHIFT;
        else if (bus.bit_valid) state_d = DONE;
      end
      DONE: begin
        if (bus.conf_ready) state_d = start_frame ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    conf_d   = conf_q;
    ones_d   = ones_q;
    perr_d   = perr_q;
    sipo_clr = start_frame;
    sipo_en  = (state_q == SHIFT) && bus.bit_valid && !start_frame;

    if (start_frame) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (sipo_en) begin
      idx_d = idx_q + CNT_W'(1);
      cnt_d = cnt_q + CNT_W'(bus.serial_in);
    end

    // Results are captured only on entry to DONE so they stay frozen while the consumer stalls.
    if ((state_q == PARITY) && bus.bit_valid && !start_frame) begin
      conf_d = sipo_q;
      ones_d = cnt_q;
      perr_d = cnt_q[0] ^ bus.serial_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      conf_q <= '0;
      ones_q <= '0;
      perr_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      conf_q <= conf_d;
      ones_q <= ones_d;
      perr_q <= perr_d;
    end
  end

  assign bus.chs_conf   = conf_q;
  assign bus.ones_count = ones_q;
  assign bus.is_even    = ~ones_q[0];
  assign bus.parity_err = perr_q;
  assign bus.conf_valid = (state_q == DONE);
  assign bus.busy       = (state_q == SHIFT) || (state_q == PARITY);

endmodule

// File: tb/tb_chs_conf_deserializer.sv
// Directed bench for chs_conf_deserializer: a frame table plus hand-written corner-case sequences.
module tb_chs_conf_deserializer;

  logic clk;
  logic rst_n;

  chs_conf_deserializer_if #(.DATA_W(8), .CNT_W(4)) bus ();

  chs_conf_deserializer #(.DATA_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cv_rises = 0;
  logic cv_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.conf_valid && !cv_prev) cv_rises++;
    cv_prev <= bus.conf_valid;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         gaps;
    logic [7:0] exp_conf;
    logic [3:0] exp_ones;
    logic       exp_even;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data bits LSB first, then parity; with gaps, bit_valid drops for one cycle after each bit.
  // Returns in the first cycle after the parity edge; checks conf_valid is still low before that edge.
  task automatic send_bits(input logic [7:0] d, input logic p, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      bus.bit_valid = 1'b1;
      bus.serial_in = d[i];
      step();
      if (gaps) begin
        bus.bit_valid = 1'b0;
        bus.serial_in = 1'b1;
        step();
      end
    end
    bus.bit_valid = 1'b1;
    bus.serial_in = p;
    chk("busy_in_parity", bus.busy, 1);
    chk("no_early_valid", bus.conf_valid, 0);
    step();
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic p, input bit gaps);
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    step();
    bus.start     = 1'b0;
    send_bits(d, p, gaps);
  endtask

  task automatic chk_result(input string tag, input logic [7:0] c, input logic [3:0] o,
                            input logic e, input logic pe);
    chk({tag, "_valid"}, bus.conf_valid, 1);
    chk({tag, "_conf"},  bus.chs_conf, c);
    chk({tag, "_ones"},  bus.ones_count, o);
    chk({tag, "_even"},  bus.is_even, e);
    chk({tag, "_perr"},  bus.parity_err, pe);
    chk({tag, "_busy"},  bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 4'd4, 1'b1, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, 1'b1};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 8'h07, 4'd3, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 8'h81, 4'd2, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};
    vecs[6] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 4'd4, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 8'h80, 4'd1, 1'b0, 1'b0};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.serial_in  = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.conf_ready = 1'b1;
    step();
    step();
    chk("rst_conf",  bus.chs_conf, 0);
    chk("rst_ones",  bus.ones_count, 0);
    chk("rst_even",  bus.is_even, 1);
    chk("rst_perr",  bus.parity_err, 0);
    chk("rst_valid", bus.conf_valid, 0);
    chk("rst_busy",  bus.busy, 0);
    rst_n = 1'b1;
    step();

    // Table of frames, consumer always ready: one-cycle conf_valid each.
    for (int k = 0; k < 8; k++) begin
      run_frame(vecs[k].data, vecs[k].par, vecs[k].gaps);
      chk_result($sformatf("vec%0d", k), vecs[k].exp_conf, vecs[k].exp_ones,
                 vecs[k].exp_even, vecs[k].exp_perr);
      step();
      chk($sformatf("vec%0d_valid_drop", k), bus.conf_valid, 0);
      chk($sformatf("vec%0d_held", k), bus.chs_conf, vecs[k].exp_conf);
      step();
    end

    // Backpressure with a stray start and bit_valid while stalled.
    bus.conf_ready = 1'b0;
    run_frame(8'h3C, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.start     = (c == 2);
      bus.bit_valid = 1'b1;
      bus.serial_in = 1'b1;
      chk_result($sformatf("bp%0d", c), 8'h3C, 4'd4, 1'b1, 1'b0);
      step();
    end
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    chk_result("bp_final", 8'h3C, 4'd4, 1'b1, 1'b0);
    bus.conf_ready = 1'b1;
    step();
    chk("bp_release_valid", bus.conf_valid, 0);
    chk("bp_release_busy",  bus.busy, 0);
    step();
    chk("bp_idle_busy", bus.busy, 0);

    // Abort after three bits, then a full frame; exactly one conf_valid.
    rises0 = cv_rises;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.serial_in = (i != 2);
      step();
    end
    chk("abort_busy", bus.busy, 1);
    run_frame(8'hFF, 1'b0, 1'b0);
    chk_result("abort", 8'hFF, 4'd8, 1'b1, 1'b0);
    step();
    chk("abort_one_valid", cv_rises - rises0, 1);
    step();

    // Back-to-back: start in the handshake cycle launches the next frame directly.
    run_frame(8'h81, 1'b0, 1'b1);
    chk_result("b2b_first", 8'h81, 4'd2, 1'b1, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("b2b_valid_drop", bus.conf_valid, 0);
    chk("b2b_busy", bus.busy, 1);
    send_bits(8'h00, 1'b0, 1'b0);
    chk_result("b2b_second", 8'h00, 4'd0, 1'b1, 1'b0);
    step();

    // Asynchronous reset mid-frame, with non-zero results held beforehand.
    run_frame(8'h07, 1'b0, 1'b0);
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid = 1'b1;
      bus.serial_in = (i % 2 == 1);
      step();
    end
    bus.bit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_conf", bus.chs_conf, 0);
    chk("mrst_ones", bus.ones_count, 0);
    chk("mrst_perr", bus.parity_err, 0);
    chk("mrst_even", bus.is_even, 1);
    step();
    #2;
    rst_n = 1'b1;
    step();
    run_frame(8'h5A, 1'b0, 1'b0);
    chk_result("post_rst", 8'h5A, 4'd4, 1'b1, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
